// File: rtl/ripple_count_sched.sv
// ripple_count_sched: round-robin scheduler sharing one windowed event counter among NREQ requesters.
// Optional saturating counter via RIPPLE_SCHED_SAT_EN (default: wrapping counter, sticky overflow). Rev 1.0
`default_nettype none

module ripple_count_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int LW   = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   win_len,
  input  logic [NREQ-1:0] evt,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            res_vld,
  output logic [IDW-1:0]  res_id,
  output logic [CW-1:0]   res_cnt,
  output logic            res_ovf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic            res_ovf_q, res_ovf_d;

  logic [IDW-1:0]  pick;
  logic [CW-1:0]   cnt_inc;
  logic            ovf_inc;

  // Scan downward so the lowest offset from ptr+1 is the one that sticks.
  function automatic logic [IDW-1:0] scan_next(input logic [IDW-1:0] ptr,
                                               input logic [NREQ-1:0] r);
    logic [IDW-1:0] sel;
    logic [IDW-1:0] idx;
    sel = ptr;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (r[idx]) sel = idx;
    end
    return sel;
  endfunction

  assign pick = scan_next(ptr_q, req);

  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = 1'b0;
    if (evt[id_q]) begin
`ifdef RIPPLE_SCHED_SAT_EN
      if (cnt_q == CNT_MAX) ovf_inc = 1'b1;
      else                  cnt_inc = cnt_q + 1'b1;
`else
      cnt_inc = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) ovf_inc = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    wcnt_d    = wcnt_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_id_d  = res_id_q;
    res_cnt_d = res_cnt_q;
    res_ovf_d = res_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d   = pick;
          wcnt_d = win_len;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          if (win_len != '0) begin
            state_d = S_COUNT;
          end else begin
            state_d   = S_REPORT;
            res_id_d  = pick;
            res_cnt_d = '0;
            res_ovf_d = 1'b0;
          end
        end
      end
      S_COUNT: begin
        if (!req[id_q]) begin
          state_d = S_IDLE;
          ptr_d   = id_q;
        end else begin
          cnt_d  = cnt_inc;
          ovf_d  = ovf_q | ovf_inc;
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == LW'(1)) begin
            state_d   = S_REPORT;
            res_id_d  = id_q;
            res_cnt_d = cnt_inc;
            res_ovf_d = ovf_q | ovf_inc;
          end
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
        ptr_d   = id_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      id_q      <= '0;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_id_q  <= '0;
      res_cnt_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_id_q  <= res_id_d;
      res_cnt_q <= res_cnt_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign gnt     = (state_q == S_COUNT) ? (NREQ'(1) << id_q) : '0;
  assign busy    = (state_q != S_IDLE);
  assign res_vld = (state_q == S_REPORT);
  assign res_id  = res_id_q;
  assign res_cnt = res_cnt_q;
  assign res_ovf = res_ovf_q;

endmodule

`default_nettype wire

// File: doc/ripple_count_sched.md
# ripple_count_sched

Round-robin scheduler that shares one event counter among several requesters. Each requester raises a request. The block grants the shared counter to one requester for a programmed window of cycles and counts that requester's event pulses. It then reports the count, the requester ID and an overflow flag in a one-cycle result beat. It sits between the counter-based measurement datapath and the client blocks that need event counts.

## Interface
- NREQ, 4: number of requesters, 2..8.
- CW, 4: event counter width.
- LW, 8: window-length width.
- IDW, $clog2(NREQ): requester ID width (derived).

- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  synchronous reset, active-high; asserted (1) resets state on the next rising edge of clk.
- req  input  NREQ  per-requester request level, held until granted and for the whole window.
- win_len  input  LW  window length in cycles, latched at grant.
- evt  input  NREQ  per-requester event, 1 = one event in this cycle; synchronous to clk.
- gnt  output  NREQ  one-hot grant, high for the whole window.
- busy  output  1  high whenever state is not IDLE.
- res_vld  output  1  one-cycle result strobe.
- res_id  output  IDW  requester ID of the result.
- res_cnt  output  CW  event count of the finished window.
- res_ovf  output  1  count exceeded 2^CW-1 during the window.

## Operation
- FSM states: IDLE, COUNT, REPORT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Pick the first set bit scanning upward from ptr+1, wrapping modulo NREQ.
  - Latch that ID and win_len into the window counter wcnt.
  - Clear cnt and the sticky ovf flag.
  - If win_len != 0, go to COUNT. If win_len == 0, go to REPORT with cnt = 0.
- COUNT, each edge:
  - If req[id] == 0, abort: go to IDLE, no result beat, ptr <= id, and evt in that cycle is ignored.
  - Otherwise cnt += evt[id] and wcnt decrements.
  - When wcnt == 1 before the decrement, go to REPORT.
- REPORT: res_vld = 1 for exactly one cycle, then ptr <= id and the FSM goes to IDLE.
- res_id, res_cnt and res_ovf are registered, loaded on entry to REPORT, and held until the next REPORT.
- gnt[id] = 1 only in COUNT; gnt is 0 in IDLE and REPORT.
- Counter overflow behaviour is set by SAT_EN (see Configuration).
- win_len and req changes for other requesters during a window have no effect.
- Reset values: state IDLE, ptr = NREQ-1 (so req[0] has highest priority first), gnt = 0, busy = 0, res_vld = 0, res_id = 0, res_cnt = 0, res_ovf = 0.
- Reset asserted mid-window: everything returns to reset values on the next edge, and no result is emitted.

## Timing
- Grant latency: req seen in IDLE at edge k gives gnt and busy high from cycle k+1.
- Window: exactly win_len COUNT cycles. evt[id] is sampled in each of them, the first being cycle k+1.
- Result: res_vld is high in cycle k+1+win_len; the FSM is in IDLE in the next cycle.
- Zero-length window: res_vld is high in cycle k+1.
- Back-to-back: the minimum period per transaction is win_len+2 cycles (one IDLE cycle between windows).
- Abort: detected at an edge in COUNT; gnt and busy drop in the next cycle.
- Pure Moore outputs: no combinational path from any input to any output.

## Configuration
- Macro: RIPPLE_SCHED_SAT_EN.
- Defined:
  - cnt saturates at 2^CW-1.
  - An increment attempted at saturation sets ovf.
  - res_cnt = 2^CW-1 whenever res_ovf = 1.
- Not defined:
  - cnt wraps modulo 2^CW.
  - ovf is still set sticky on the wrap from 2^CW-1 to 0.
  - res_cnt is the wrapped value.

## Test plan
- Reset, then req = 4'b0001, win_len = 5, evt[0] high for 3 of the 5 COUNT cycles:
  - gnt = 0001 for 5 cycles.
  - res_vld with res_id = 0, res_cnt = 3, res_ovf = 0.
- req = 4'b1111 held, win_len = 1, evt = 0:
  - Grant order 0,1,2,3,0.
  - One res_vld every 3 cycles, with res_cnt = 0 each time.
- req = 4'b0100, win_len = 20, evt[2] = 1 every cycle:
  - With SAT_EN: res_cnt = 15, res_ovf = 1.
  - Without SAT_EN: res_cnt = 4, res_ovf = 1.
- req = 4'b0010, win_len = 10, req[1] dropped after 4 COUNT cycles:
  - gnt falls on the next cycle.
  - No res_vld.
  - A following req = 4'b0011 grants requester 0 first (ptr = 1, so the scan starts at 2 and wraps to 0).
- win_len = 0 with req = 4'b1000:
  - res_vld with res_id = 3, res_cnt = 0 one cycle after the grant decision.
  - gnt never asserted.
- Reset (rstn = 1) asserted in the 3rd COUNT cycle:
  - All outputs are 0 on the next cycle and no result is emitted.
  - After release, req = 4'b0011 grants requester 0 first.
